// File: rtl/addsub_pkg.sv
// Shared types and helpers for the pipelined add/subtract datapath.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package addsub_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ADC = 2'b10,
    OP_SBB = 2'b11
  } op_e;

  typedef struct packed {
    logic c;
    logic v;
    logic z;
    logic n;
  } flags_t;

  // Bits of the carry chain resolved per pipeline stage.
  function automatic int slice_w(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational W-bit slice adder with carry in/out; one per pipeline stage.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the enclosing stage register does the holding.
module adder_slice #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  // One extra bit on the add so the carry-out is the top bit of the result.
  always_comb begin
    {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  end

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined ADD/SUB/ADC/SBB with NZCV flags; carry chain cut into STAGES slices.
// Latency: STAGES cycles from accept to out_valid; one op per cycle.
// Backpressure: global all-or-nothing stall while out_valid & ~out_ready. Option: ADDSUB_SAT_EN adds sat port.
module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef ADDSUB_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_z,
  output logic             flag_n
);

  localparam int SW = slice_w(WIDTH, STAGES);

  if (WIDTH % STAGES != 0) begin : g_bad_width
    $error("pipelined_addsub: WIDTH must be divisible by STAGES");
  end
  if (STAGES < 1 || STAGES > 8) begin : g_bad_stages
    $error("pipelined_addsub: STAGES must be in 1..8");
  end

  // Inputs seen by each stage: stage 0 from the ports, stage k from stage k-1 registers.
  logic [WIDTH-1:0] st_a [STAGES];
  logic [WIDTH-1:0] st_b [STAGES];
  logic [WIDTH-1:0] st_r [STAGES];
  logic             st_c [STAGES];
  logic             st_v [STAGES];
`ifdef ADDSUB_SAT_EN
  logic             st_s [STAGES];
`endif

  logic             advance;
  op_e              op_sel;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  logic             out_valid_d, out_valid_q;
  logic [WIDTH-1:0] result_d, result_q;
  flags_t           flags_d, flags_q;

  assign advance  = ~out_valid_q | out_ready;
  assign in_ready = advance;

  // Subtraction is a + ~b + carry; ADC/SBB take their carry from cin.
  always_comb begin
    op_sel = op_e'(op);
    b_eff  = b;
    c0     = 1'b0;
    case (op_sel)
      OP_ADD: begin b_eff = b;  c0 = 1'b0; end
      OP_SUB: begin b_eff = ~b; c0 = 1'b1; end
      OP_ADC: begin b_eff = b;  c0 = cin;  end
      OP_SBB: begin b_eff = ~b; c0 = cin;  end
      default: begin b_eff = b; c0 = 1'b0; end
    endcase
  end

  assign st_a[0] = a;
  assign st_b[0] = b_eff;
  assign st_r[0] = '0;
  assign st_c[0] = c0;
  assign st_v[0] = in_valid;
`ifdef ADDSUB_SAT_EN
  assign st_s[0] = sat;
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SW-1:0] sum;
    logic          cout;

    adder_slice #(.W(SW)) u_slice (
      .a    (st_a[k][k*SW +: SW]),
      .b    (st_b[k][k*SW +: SW]),
      .cin  (st_c[k]),
      .sum  (sum),
      .cout (cout)
    );

    if (k < STAGES - 1) begin : g_mid
      localparam int DW = (k + 1) * SW;  // result bits resolved so far
      localparam int UW = WIDTH - DW;    // operand bits still to add

      logic [UW-1:0] a_d, a_q, b_d, b_q;
      logic [DW-1:0] r_d, r_q;
      logic          c_d, c_q, v_d, v_q;
`ifdef ADDSUB_SAT_EN
      logic          s_d, s_q;
`endif

      // Capture this slice's sum and carry plus the pending upper operand bits.
      always_comb begin
        a_d = a_q;
        b_d = b_q;
        r_d = r_q;
        c_d = c_q;
        v_d = v_q;
`ifdef ADDSUB_SAT_EN
        s_d = s_q;
`endif
        if (advance) begin
          a_d = st_a[k][WIDTH-1 -: UW];
          b_d = st_b[k][WIDTH-1 -: UW];
          r_d = st_r[k][DW-1:0] | (DW'(sum) << (k * SW));
          c_d = cout;
          v_d = st_v[k];
`ifdef ADDSUB_SAT_EN
          s_d = st_s[k];
`endif
        end
      end

      // Stage register; cleared on reset so in-flight ops are dropped.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
          r_q <= '0;
          c_q <= 1'b0;
          v_q <= 1'b0;
`ifdef ADDSUB_SAT_EN
          s_q <= 1'b0;
`endif
        end else begin
          a_q <= a_d;
          b_q <= b_d;
          r_q <= r_d;
          c_q <= c_d;
          v_q <= v_d;
`ifdef ADDSUB_SAT_EN
          s_q <= s_d;
`endif
        end
      end

      assign st_a[k+1] = {a_q, {DW{1'b0}}};
      assign st_b[k+1] = {b_q, {DW{1'b0}}};
      assign st_r[k+1] = {{UW{1'b0}}, r_q};
      assign st_c[k+1] = c_q;
      assign st_v[k+1] = v_q;
`ifdef ADDSUB_SAT_EN
      assign st_s[k+1] = s_q;
`endif
    end else begin : g_last
      logic [WIDTH-1:0] sum_full;
      logic [WIDTH-1:0] res;
      logic             a_msb;
      logic             ovf;

      // Final slice: assemble the full result, derive flags, optionally clamp.
      always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        flags_d     = flags_q;
        sum_full    = st_r[k] | (WIDTH'(sum) << (k * SW));
        a_msb       = st_a[k][WIDTH-1];
        ovf         = (a_msb == st_b[k][WIDTH-1]) & (sum_full[WIDTH-1] != a_msb);
        res         = sum_full;
`ifdef ADDSUB_SAT_EN
        if (st_s[k] && ovf) begin
          res = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
        if (advance) begin
          out_valid_d = st_v[k];
          // Bubbles leave the last result in place rather than loading junk.
          if (st_v[k]) begin
            result_d  = res;
            flags_d.c = cout;
            flags_d.v = ovf;
            flags_d.z = ~|res;
            flags_d.n = res[WIDTH-1];
          end
        end
      end
    end
  end

  // Output register; async reset drops out_valid immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flag_c    = flags_q.c;
  assign flag_v    = flags_q.v;
  assign flag_z    = flags_q.z;
  assign flag_n    = flags_q.n;

endmodule
